// File: rtl/paddle_controller.sv
`default_nettype none
// ============================================================================
// Module      : paddle_controller
// Description : Two-paddle Pong controller. Holds both paddle Y positions,
//               moves them once per frame from button requests with
//               hold-to-accelerate speed, and renders both paddles as a
//               registered 1-bit RGB overlay (one cycle of latency).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk           in   1   pixel clock
//   i_reset         in   1   asynchronous, active-high reset
//   i_frame_tick    in   1   one-cycle pulse per frame, during vertical blanking
//   i_up            in   2   [0]=left, [1]=right paddle up request
//   i_down          in   2   down requests, same mapping
//   i_ball_y        in  10   ball top y (used only when PADDLE_AI_EN is defined)
//   i_pixel_x       in  10   current pixel x
//   i_pixel_y       in  10   current pixel y
//   i_visible_area  in   1   current pixel lies in the visible area
//   o_paddle1_y     out 10   left paddle top y
//   o_paddle2_y     out 10   right paddle top y
//   o_r/o_g/o_b     out  1   paddle overlay colour
// Build option
//   PADDLE_AI_EN : when defined, the right paddle tracks i_ball_y with a
//                  +/-4 px deadband at fixed MIN_SPEED and ignores its buttons.
// ============================================================================
module paddle_controller #(
    parameter int PADDLE_MARGIN = 30,
    parameter int PADDLE_H      = 50,
    parameter int PADDLE_W      = 10,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int MIN_SPEED     = 2,
    parameter int MAX_SPEED     = 8,
    parameter int ACCEL_FRAMES  = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic [1:0] i_up,
    input  logic [1:0] i_down,
    input  logic [9:0] i_ball_y,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic       i_visible_area,
    output logic [9:0] o_paddle1_y,
    output logic [9:0] o_paddle2_y,
    output logic       o_r,
    output logic       o_g,
    output logic       o_b
);

    // Geometry in 11 bits so that y+speed and y+PADDLE_H never wrap.
    localparam logic [10:0] c_Y_MAX   = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] c_Y_RESET = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] c_X1      = 11'(PADDLE_MARGIN);
    localparam logic [10:0] c_X2      = 11'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);
    localparam logic [10:0] c_PW      = 11'(PADDLE_W);
    localparam logic [10:0] c_PH      = 11'(PADDLE_H);
    localparam logic [10:0] c_PH_HALF = 11'(PADDLE_H / 2);
    localparam logic [10:0] c_DEADBAND = 11'd4;

    localparam int c_SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int c_HOLD_W = $clog2(ACCEL_FRAMES + 1);

    // Per-paddle FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_UP   = 2'd1;
    localparam logic [1:0] c_DOWN = 2'd2;

    // Current positions of both paddles, exported from the per-paddle blocks
    logic [10:0] w_y [2];

    // ------------------------------------------------------------------------
    // Paddle motion: one identical engine per paddle
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_paddle
        logic [1:0]          r_state;
        logic [c_SPD_W-1:0]  r_speed;
        logic [c_HOLD_W-1:0] r_hold;
        logic [10:0]         r_y;

        logic                w_req_up;
        logic                w_req_dn;
        logic [1:0]          w_next;
        logic                w_restart;
        logic [c_SPD_W-1:0]  w_step;
        logic [10:0]         w_step_ext;
        logic [10:0]         w_sum;
        logic [10:0]         w_y_next;
        logic [c_HOLD_W-1:0] w_hold_inc;

`ifdef PADDLE_AI_EN
        // The AI-driven right paddle never accelerates.
        localparam bit c_ACCEL = (k != 1);

        if (k == 1) begin : g_ai
            logic [10:0] w_ball;
            logic [10:0] w_center;
            logic [1:0]  w_unused_btn;

            assign w_ball       = {1'b0, i_ball_y};
            assign w_center     = r_y + c_PH_HALF;
            // center >= PADDLE_H/2 > deadband, so center-4 cannot underflow
            assign w_req_up     = (w_ball < (w_center - c_DEADBAND));
            assign w_req_dn     = (w_ball > (w_center + c_DEADBAND));
            assign w_unused_btn = {i_up[1], i_down[1]};
        end else begin : g_btn
            assign w_req_up = i_up[k];
            assign w_req_dn = i_down[k];
        end
`else
        localparam bit c_ACCEL = 1'b1;

        assign w_req_up = i_up[k];
        assign w_req_dn = i_down[k];
`endif

        always_comb begin
            w_next = c_IDLE;
            if (w_req_up && !w_req_dn) begin
                w_next = c_UP;
            end else if (w_req_dn && !w_req_up) begin
                w_next = c_DOWN;
            end

            // Releasing or reversing starts the speed ramp over. Starting to
            // move from IDLE is a normal moving frame: speed is already at
            // MIN_SPEED and the frame counts toward the first speed step.
            w_restart = (w_next == c_IDLE) ||
                        ((r_state != c_IDLE) && (w_next != r_state));

            // A reversal moves at the restarted speed; otherwise the speed
            // held before this tick's increment is used.
            w_step     = w_restart ? c_SPD_W'(MIN_SPEED) : r_speed;
            w_step_ext = 11'(w_step);
            w_sum      = r_y + w_step_ext;
            w_hold_inc = r_hold + c_HOLD_W'(1);

            w_y_next = r_y;
            if (w_next == c_UP) begin
                w_y_next = (r_y < w_step_ext) ? 11'd0 : (r_y - w_step_ext);
            end else if (w_next == c_DOWN) begin
                w_y_next = (w_sum > c_Y_MAX) ? c_Y_MAX : w_sum;
            end
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_state <= c_IDLE;
                r_speed <= c_SPD_W'(MIN_SPEED);
                r_hold  <= '0;
                r_y     <= c_Y_RESET;
            end else if (i_frame_tick) begin
                r_state <= w_next;
                r_y     <= w_y_next;
                if (w_restart || !c_ACCEL) begin
                    r_speed <= c_SPD_W'(MIN_SPEED);
                    r_hold  <= '0;
                end else if (w_hold_inc == c_HOLD_W'(ACCEL_FRAMES)) begin
                    r_hold <= '0;
                    if (r_speed < c_SPD_W'(MAX_SPEED)) begin
                        r_speed <= r_speed + c_SPD_W'(1);
                    end
                end else begin
                    r_hold <= w_hold_inc;
                end
            end
        end

        assign w_y[k] = r_y;
    end

`ifndef PADDLE_AI_EN
    logic w_unused_ball;
    assign w_unused_ball = ^i_ball_y;
`endif

    assign o_paddle1_y = w_y[0][9:0];
    assign o_paddle2_y = w_y[1][9:0];

    // ------------------------------------------------------------------------
    // Overlay render: top row inclusive, bottom row / right column exclusive
    // ------------------------------------------------------------------------
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic        w_hit1;
    logic        w_hit2;
    logic        r_pix;

    always_comb begin
        w_px   = {1'b0, i_pixel_x};
        w_py   = {1'b0, i_pixel_y};
        w_hit1 = (w_px >= c_X1) && (w_px < (c_X1 + c_PW)) &&
                 (w_py >= w_y[0]) && (w_py < (w_y[0] + c_PH));
        w_hit2 = (w_px >= c_X2) && (w_px < (c_X2 + c_PW)) &&
                 (w_py >= w_y[1]) && (w_py < (w_y[1] + c_PH));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pix <= 1'b0;
        end else begin
            r_pix <= i_visible_area && (w_hit1 || w_hit2);
        end
    end

    assign o_r = r_pix;
    assign o_g = r_pix;
    assign o_b = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_paddle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_controller
// Description : Self-checking bench for paddle_controller. Paddle motion is
//               compared against a behavioural model after every frame tick;
//               the render path is driven from a vector table with expected
//               pixels queued and popped one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_controller;

    localparam int Y_MAX   = 430;
    localparam int Y_RESET = 215;
    localparam int MIN_SPD = 2;
    localparam int MAX_SPD = 8;
    localparam int ACCEL   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [1:0] up;
    logic [1:0] down;
    logic [9:0] ball_y;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       visible;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic       r_out, g_out, b_out;

    paddle_controller dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_frame_tick   (frame_tick),
        .i_up           (up),
        .i_down         (down),
        .i_ball_y       (ball_y),
        .i_pixel_x      (pixel_x),
        .i_pixel_y      (pixel_y),
        .i_visible_area (visible),
        .o_paddle1_y    (paddle1_y),
        .o_paddle2_y    (paddle2_y),
        .o_r            (r_out),
        .o_g            (g_out),
        .o_b            (b_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: st 0=idle, 1=up, 2=down
    int m_y   [2];
    int m_spd [2];
    int m_hold[2];
    int m_st  [2];

    bit exp_q[$];

    typedef struct {
        int x;
        int y;
        bit vis;
        bit exp;
    } pix_vec_t;

    pix_vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_y[k]    = Y_RESET;
            m_spd[k]  = MIN_SPD;
            m_hold[k] = 0;
            m_st[k]   = 0;
        end
    endtask

    task automatic model_tick(input int k, input bit req_up, input bit req_dn);
        int  nxt;
        int  step;
        bit  accel;
        bit  u;
        bit  d;
        u     = req_up;
        d     = req_dn;
        accel = 1'b1;
`ifdef PADDLE_AI_EN
        if (k == 1) begin
            u     = (int'(ball_y) < m_y[1] + 25 - 4);
            d     = (int'(ball_y) > m_y[1] + 25 + 4);
            accel = 1'b0;
        end
`endif
        if (u && !d)      nxt = 1;
        else if (d && !u) nxt = 2;
        else              nxt = 0;

        if (nxt == 0 || (m_st[k] != 0 && nxt != m_st[k])) begin
            m_spd[k]  = MIN_SPD;
            m_hold[k] = 0;
            step      = MIN_SPD;
        end else begin
            step = m_spd[k];
            if (accel) begin
                m_hold[k]++;
                if (m_hold[k] == ACCEL) begin
                    m_hold[k] = 0;
                    if (m_spd[k] < MAX_SPD) m_spd[k]++;
                end
            end
        end

        if (nxt == 1)      m_y[k] = (m_y[k] < step) ? 0 : m_y[k] - step;
        else if (nxt == 2) m_y[k] = (m_y[k] + step > Y_MAX) ? Y_MAX : m_y[k] + step;
        m_st[k] = nxt;
    endtask

    // One frame tick with the given requests; positions compared afterwards.
    task automatic do_tick(input logic [1:0] u, input logic [1:0] d);
        @(negedge clk);
        up         = u;
        down       = d;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(0, u[0], d[0]);
        model_tick(1, u[1], d[1]);
        check("tick_y1", 32'(paddle1_y), m_y[0]);
        check("tick_y2", 32'(paddle2_y), m_y[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic bit pix_model(input int x, input int y, input bit vis);
        bit h1;
        bit h2;
        h1 = (x >= 30)  && (x < 40)  && (y >= m_y[0]) && (y < m_y[0] + 50);
        h2 = (x >= 600) && (x < 610) && (y >= m_y[1]) && (y < m_y[1] + 50);
        return vis && (h1 || h2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pexp;
        rst        = 1'b1;
        frame_tick = 1'b0;
        up         = 2'b00;
        down       = 2'b00;
        ball_y     = 10'd100;
        pixel_x    = 10'd0;
        pixel_y    = 10'd0;
        visible    = 1'b0;
        model_reset();

        //                  x    y    vis  exp   (both paddles at y=215)
        vecs[0]  = '{30,  215, 1'b1, 1'b1};
        vecs[1]  = '{40,  215, 1'b1, 1'b0};
        vecs[2]  = '{30,  265, 1'b1, 1'b0};
        vecs[3]  = '{39,  264, 1'b1, 1'b1};
        vecs[4]  = '{29,  215, 1'b1, 1'b0};
        vecs[5]  = '{30,  214, 1'b1, 1'b0};
        vecs[6]  = '{600, 215, 1'b1, 1'b1};
        vecs[7]  = '{609, 240, 1'b1, 1'b1};
        vecs[8]  = '{610, 240, 1'b1, 1'b0};
        vecs[9]  = '{600, 215, 1'b0, 1'b0};
        vecs[10] = '{30,  215, 1'b0, 1'b0};
        vecs[11] = '{300, 300, 1'b1, 1'b0};

        // ---- Reset state; no ticks means no movement ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_y1", 32'(paddle1_y), Y_RESET);
        check("rst_y2", 32'(paddle2_y), Y_RESET);
        check("rst_rgb", 32'({r_out, g_out, b_out}), 0);
        up = 2'b11;
        repeat (10) @(negedge clk);
        up = 2'b00;
        check("hold_y1", 32'(paddle1_y), Y_RESET);
        check("hold_y2", 32'(paddle2_y), Y_RESET);

        // ---- Left paddle held down: 217,219,221,223,226 ----
        for (int i = 0; i < 5; i++) do_tick(2'b00, 2'b01);
        check("accel_y1", 32'(paddle1_y), 226);
        do_tick(2'b00, 2'b00);

`ifndef PADDLE_AI_EN
        // ---- Right paddle walked to y=3 in single steps, then top clamp ----
        while (m_y[1] > 3) begin
            do_tick(2'b10, 2'b00);
            do_tick(2'b00, 2'b00);
        end
        do_tick(2'b10, 2'b00);
        check("top_y2_1", 32'(paddle2_y), 1);
        do_tick(2'b10, 2'b00);
        check("top_y2_0", 32'(paddle2_y), 0);
        repeat (3) do_tick(2'b10, 2'b00);
        check("top_y2_hold", 32'(paddle2_y), 0);
        do_tick(2'b00, 2'b00);

        // ---- Walk down to 428, then bottom clamp ----
        while (m_y[1] < 428) begin
            do_tick(2'b00, 2'b10);
            do_tick(2'b00, 2'b00);
        end
        do_tick(2'b00, 2'b10);
        check("bot_y2", 32'(paddle2_y), Y_MAX);
        repeat (3) do_tick(2'b00, 2'b10);
        check("bot_y2_hold", 32'(paddle2_y), Y_MAX);
        do_tick(2'b00, 2'b00);
`endif

        // ---- Both pressed: no motion; 8 held ticks then reversal ----
        for (int i = 0; i < 3; i++) do_tick(2'b01, 2'b01);
        check("both_y1", 32'(paddle1_y), 226);
        for (int i = 0; i < 8; i++) do_tick(2'b01, 2'b00);
        check("held8_y1", 32'(paddle1_y), 206);
        do_tick(2'b00, 2'b01);
        do_tick(2'b00, 2'b01);
        check("rev_y1", 32'(paddle1_y), 210);
        do_tick(2'b00, 2'b00);

        // ---- Short random run of both paddles against the model ----
        for (int i = 0; i < 40; i++) begin
            do_tick(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
        end

        // ---- Render table at centred paddles, back-to-back via scoreboard ----
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                pexp = exp_q.pop_front();
                check("pix", 32'({r_out, g_out, b_out}), pexp ? 7 : 0);
            end
            pixel_x = 10'(vecs[i].x);
            pixel_y = 10'(vecs[i].y);
            visible = vecs[i].vis;
            exp_q.push_back(vecs[i].exp);
            check("pix_model", 32'(pix_model(vecs[i].x, vecs[i].y, vecs[i].vis)),
                  int'(vecs[i].exp));
        end
        @(negedge clk);
        pexp = exp_q.pop_front();
        check("pix_last", 32'({r_out, g_out, b_out}), pexp ? 7 : 0);

        // ---- Mid-frame reset: output clears at once, render resumes ----
        do_tick(2'b00, 2'b01);
        pixel_x = 10'd30;
        pixel_y = 10'd230;
        visible = 1'b1;
        @(negedge clk);
        check("pre_rst_rgb", 32'({r_out, g_out, b_out}), 7);
        #2;
        rst = 1'b1;
        #1;
        check("async_rgb", 32'({r_out, g_out, b_out}), 0);
        check("async_y1", 32'(paddle1_y), Y_RESET);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("in_rst_rgb", 32'({r_out, g_out, b_out}), 0);
        @(negedge clk);
        check("resume_rgb", 32'({r_out, g_out, b_out}), 7);
        visible = 1'b0;

`ifdef PADDLE_AI_EN
        // ---- AI right paddle: deadband hold, then tracking at MIN speed ----
        do_reset();
        ball_y = 10'd240;
        for (int i = 0; i < 3; i++) do_tick(2'b10, 2'b00);
        check("ai_dead_y2", 32'(paddle2_y), Y_RESET);
        ball_y = 10'd100;
        for (int i = 0; i < 6; i++) do_tick(2'b00, 2'b00);
        check("ai_track_y2", 32'(paddle2_y), Y_RESET - 12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
